// File: rtl/coef_pkg.sv
// coef_pkg: shared state encodings, default widths and bank count for coef_bank.
package coef_pkg;
  localparam int DATA_W_DEF = 14;
  localparam int DEPTH_DEF = 16;
  localparam int NUM_RD_DEF = 2;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;
`ifdef COEF_BANK_PINGPONG_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif
endpackage

// File: rtl/coef_load_ctrl.sv
// coef_load_ctrl: sequential load FSM, write pointer, done/valid status and bank select.
// COEF_BANK_PINGPONG_EN: bank select toggles on each completed load and bank_valid stays sticky.
module coef_load_ctrl
  import coef_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  output logic              ld_done_o,
  output logic              bank_valid_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              sel_o
);
  logic [0:0] state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic valid_q, valid_d, sel_q, sel_d;
  always_comb begin
    ld_ready_o = state_q == ST_LOAD;
    // a start pulse always wins: the word offered alongside it is dropped
    we_o = ld_ready_o && ld_valid_i && !ld_start_i;
    ld_done_o = we_o && ptr_q == ADDR_W'(DEPTH - 1);
    state_d = ld_start_i ? ST_LOAD : ld_done_o ? ST_IDLE : state_q;
    ptr_d = (ld_start_i || ld_done_o) ? '0 : we_o ? ptr_q + 1'b1 : ptr_q;
`ifdef COEF_BANK_PINGPONG_EN
    valid_d = valid_q || ld_done_o;
    sel_d = sel_q ^ ld_done_o;
`else
    valid_d = ld_start_i ? 1'b0 : ld_done_o ? 1'b1 : valid_q;
    sel_d = 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      valid_q <= 1'b0;
      sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      valid_q <= valid_d;
      sel_q <= sel_d;
    end
  end
  assign bank_valid_o = valid_q;
  assign wr_addr_o = ptr_q;
  assign sel_o = sel_q;
endmodule

// File: rtl/coef_bank.sv
// coef_bank: coefficient store with handshaked sequential load and NUM_RD registered read ports.
// COEF_BANK_PINGPONG_EN: two banks, loads fill the shadow bank and swap on completion.
module coef_bank
  import coef_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_start_i,
  input  logic                     ld_valid_i,
  output logic                     ld_ready_o,
  input  logic [DATA_W-1:0]        ld_data_i,
  output logic                     ld_done_o,
  output logic                     bank_valid_o,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_valid_o
);
  logic we, sel, wb;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] mem_q [NUM_BANKS][DEPTH];
  coef_load_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ctrl (
    .clk(clk),
    .rst(rst),
    .ld_start_i(ld_start_i),
    .ld_valid_i(ld_valid_i),
    .ld_ready_o(ld_ready_o),
    .ld_done_o(ld_done_o),
    .bank_valid_o(bank_valid_o),
    .we_o(we),
    .wr_addr_o(wa),
    .sel_o(sel)
  );
  // with two banks the writer targets the bank the readers are not using
  assign wb = sel ^ (NUM_BANKS == 2);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int i = 0; i < DEPTH; i++)
          mem_q[b][i] <= '0;
    end else if (we) begin
      mem_q[wb][wa] <= ld_data_i;
    end
  end
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic rd_valid_q;
    assign a = rd_addr_i[p*ADDR_W +: ADDR_W];
    assign rd_data_d = (bank_valid_o && 32'(a) < DEPTH) ? mem_q[sel][a] : '0;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_en_i[p];
        if (rd_en_i[p]) rd_data_q <= rd_data_d;
      end
    end
    assign rd_data_o[p*DATA_W +: DATA_W] = rd_data_q;
    assign rd_valid_o[p] = rd_valid_q;
  end
endmodule

// File: tb/tb_coef_bank.sv
// tb_coef_bank: directed and random stimulus checked against a queue-based load/read model.
module tb_coef_bank;
  localparam int DW = 14;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int NR = 2;
`ifdef COEF_BANK_PINGPONG_EN
  localparam bit PP = 1;
`else
  localparam bit PP = 0;
`endif
  logic clk = 0, rst = 1;
  logic ld_start = 0, ld_valid = 0, ld_ready, ld_done, bank_valid;
  logic [DW-1:0] ld_data = '0;
  logic [NR-1:0] rd_en = '0, rd_valid;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  int checks = 0, errors = 0, done_cnt = 0;

  coef_bank dut (
    .clk(clk), .rst(rst),
    .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_ready_o(ld_ready),
    .ld_data_i(ld_data), .ld_done_o(ld_done), .bank_valid_o(bank_valid),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: words of the current load collect in a queue and become
  // visible as a whole only when DEPTH of them have been accepted.
  logic [DW-1:0] bm [2][DEPTH];
  int act;
  bit loading, mvalid;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd [NR];
  bit m_rv [NR];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (bm[b, i]) bm[b][i] = '0;
      act = 0; loading = 0; mvalid = 0; q.delete();
      for (int p = 0; p < NR; p++) begin m_rd[p] = '0; m_rv[p] = 0; end
    end else begin
      for (int p = 0; p < NR; p++) begin
        int a;
        a = int'(rd_addr[p*AW +: AW]);
        m_rv[p] = rd_en[p];
        if (rd_en[p]) m_rd[p] = (mvalid && a < DEPTH) ? bm[act][a] : '0;
      end
      if (ld_start) begin
        loading = 1; q.delete();
        if (!PP) mvalid = 0;
      end else if (loading && ld_valid) begin
        q.push_back(ld_data);
        if (q.size() == DEPTH) begin
          int t;
          t = PP ? 1 - act : 0;
          for (int i = 0; i < DEPTH; i++) bm[t][i] = q[i];
          act = t; mvalid = 1; loading = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ld_ready", ld_ready, loading);
      chk("ld_done", ld_done, loading && ld_valid && !ld_start && q.size() == DEPTH - 1);
      chk("bank_valid", bank_valid, mvalid);
      for (int p = 0; p < NR; p++) begin
        chk("rd_valid", rd_valid[p], m_rv[p]);
        chk("rd_data", int'(rd_data[p*DW +: DW]), int'(m_rd[p]));
      end
      if (ld_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(int p, bit en, int a);
    rd_en[p] = en;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic load(int base, int n, bit tog);
    int i;
    ld_start = 1; ld_valid = 0;
    tick();
    ld_start = 0;
    i = 0;
    while (i < n) begin
      ld_valid = tog ? ~ld_valid : 1'b1;
      ld_data = DW'(base + i);
      if (ld_valid && i == DEPTH - 1) begin
        #1;
        chk("ld_done_last_word", ld_done, 1);
      end
      if (ld_valid) i++;
      tick();
    end
    ld_valid = 0;
  endtask

  task automatic read1(int p, int a, int exp, string name);
    set_rd(p, 1, a);
    tick();
    set_rd(p, 0, 0);
    chk(name, int'(rd_data[p*DW +: DW]), exp);
  endtask

  initial begin
    int d0;
    tick(); tick();
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_bank_valid", bank_valid, 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    rst = 0;
    tick();
    // 1: plain load and a single read
    d0 = done_cnt;
    load(0, DEPTH, 0);
    chk("t1_done_count", done_cnt - d0, 1);
    read1(0, 5, 5, "t1_addr5");
    // 2: valid toggling
    d0 = done_cnt;
    load(20, DEPTH, 1);
    chk("t2_done_count", done_cnt - d0, 1);
    read1(1, 7, 27, "t2_addr7");
    read1(0, 15, 35, "t2_addr15");
    // 3: restart after 7 words
    d0 = done_cnt;
    load(50, 7, 0);
    load(100, DEPTH, 0);
    chk("t3_done_count", done_cnt - d0, 1);
    read1(0, 3, 103, "t3_addr3");
    // 4: both ports at once, then hold
    set_rd(0, 1, 15); set_rd(1, 1, 0);
    tick();
    chk("t4_p0", int'(rd_data[0 +: DW]), 115);
    chk("t4_p1", int'(rd_data[DW +: DW]), 100);
    chk("t4_valid", int'(rd_valid), 3);
    set_rd(0, 0, 0); set_rd(1, 0, 0);
    tick();
    chk("t4_hold_valid", int'(rd_valid), 0);
    chk("t4_hold_p0", int'(rd_data[0 +: DW]), 115);
    // 5: reload while streaming reads of addr 4
    load(0, DEPTH, 0);
    set_rd(0, 1, 4);
    ld_start = 1;
    tick();
    ld_start = 0;
    tick();
    chk("t5_mid_read", int'(rd_data[0 +: DW]), PP ? 4 : 0);
    chk("t5_mid_bank_valid", bank_valid, PP ? 1 : 0);
    load(200, DEPTH, 0);
    tick();
    chk("t5_after", int'(rd_data[0 +: DW]), 204);
    set_rd(0, 0, 0);
    // 6: reset during a load
    load(300, 9, 0);
    ld_valid = 1; ld_data = 14'd999;
    rst = 1;
    #1;
    chk("t6_ready", ld_ready, 0);
    chk("t6_done", ld_done, 0);
    chk("t6_bank_valid", bank_valid, 0);
    chk("t6_rd", int'(rd_data) | int'(rd_valid), 0);
    ld_valid = 0;
    tick();
    rst = 0;
    tick();
    read1(0, 4, 0, "t6_read_after");
    chk("t6_bv_after", bank_valid, 0);
    // random phase
    for (int c = 0; c < 3000; c++) begin
      ld_start = ($urandom_range(0, 59) == 0);
      ld_valid = ($urandom_range(0, 9) < 7);
      ld_data = DW'($urandom);
      for (int p = 0; p < NR; p++) set_rd(p, $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1));
      tick();
    end
    ld_start = 0; ld_valid = 0; rd_en = '0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
